// File: rtl/req_onehot_arbiter.sv
// Request synchroniser, edge capture and one-hot arbiter
// feeding the 4-to-2 encoder stage over valid/ready.
module req_onehot_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter bit RR_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic       clr_ovf,
  input  logic       ready_in,
  output logic [3:0] onehot_out,
  output logic       valid_out,
  output logic [3:0] pending_out,
  output logic       ovf
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;
  logic [3:0] p_q;
  logic [3:0] e;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] ld;
  logic [1:0] ptr_q;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       free;
  logic       load;
  logic       ovf_set;

  assign s           = sync_q[SYNC_STAGES-1];
  assign e           = s & ~p_q;
  assign free        = !valid_out || ready_in;
  assign load        = free && (pend_q != 4'b0000);
  assign pending_out = pend_q;

  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    if (RR_EN) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && pend_q[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (pend_q[k]) win = 2'(k);
    end
  end

  // A bit being granted this edge may simultaneously re-arm from a new edge.
  assign ld      = load ? (4'b0001 << win) : 4'b0000;
  assign pend_d  = (pend_q & ~ld) | e;
  assign ovf_set = |(e & pend_q & ~ld);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= 4'b0000;
      p_q        <= 4'b0000;
      pend_q     <= 4'b0000;
      onehot_out <= 4'b0000;
      valid_out  <= 1'b0;
      ovf        <= 1'b0;
      ptr_q      <= 2'd0;
    end else begin
      sync_q[0] <= req_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      p_q    <= s;
      pend_q <= pend_d;
      if (free) begin
        onehot_out <= ld;
        valid_out  <= load;
      end
      if (load && RR_EN)
        ptr_q <= win + 2'd1;
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Bench for req_onehot_arbiter: round-robin and fixed-priority
// instances against a cycle-level behavioural reference.
module tb_req_onehot_arbiter;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_in = 4'b0000;
  logic       clr_ovf = 1'b0;
  logic       ready_in = 1'b0;

  logic [3:0] oh_rr, pd_rr, oh_fp, pd_fp;
  logic       vld_rr, ovf_rr, vld_fp, ovf_fp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rst = -1;

  logic [3:0] reqlog [0:8191];
  logic [3:0] m_pend [2];
  logic [3:0] m_oh [2];
  logic       m_vld [2];
  logic       m_ovf [2];
  int         m_ptr;

  req_onehot_arbiter #(.SYNC_STAGES(SYNC), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr_ovf(clr_ovf),
    .ready_in(ready_in), .onehot_out(oh_rr), .valid_out(vld_rr),
    .pending_out(pd_rr), .ovf(ovf_rr)
  );

  req_onehot_arbiter #(.SYNC_STAGES(SYNC), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr_ovf(clr_ovf),
    .ready_in(ready_in), .onehot_out(oh_fp), .valid_out(vld_fp),
    .pending_out(pd_fp), .ovf(ovf_fp)
  );

  always #5 clk = ~clk;

  // Synchronised level seen after edge c: the input sampled SYNC-1 edges
  // earlier, or zero if that sample predates the most recent reset.
  function automatic logic [3:0] s_at(int c);
    int j;
    j = c - SYNC + 1;
    if (j < 0 || j <= last_rst) return 4'b0000;
    return reqlog[j];
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] e, ld;
    logic       free;
    int         w;
    e = s_at(cyc - 1) & ~s_at(cyc - 2);
    reqlog[cyc] = req_in;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_pend[d] = 0; m_oh[d] = 0; m_vld[d] = 0; m_ovf[d] = 0;
      end
      m_ptr = 0;
      last_rst = cyc;
    end else begin
      for (int d = 0; d < 2; d++) begin
        ld = 0;
        w = -1;
        free = !m_vld[d] || ready_in;
        if (free && m_pend[d] != 0) begin
          if (d == 0) begin
            for (int k = 0; k < 4; k++)
              if (w < 0 && m_pend[d][(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            m_ptr = (w + 1) % 4;
          end else begin
            for (int k = 3; k >= 0; k--)
              if (w < 0 && m_pend[d][k]) w = k;
          end
          ld = 4'(1 << w);
        end
        if ((e & m_pend[d] & ~ld) != 0) m_ovf[d] = 1'b1;
        else if (clr_ovf) m_ovf[d] = 1'b0;
        m_pend[d] = (m_pend[d] & ~ld) | e;
        if (free) begin
          m_oh[d] = ld;
          m_vld[d] = (ld != 0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("rr_onehot", oh_rr, m_oh[0]);
    chk("rr_valid", {3'b0, vld_rr}, {3'b0, m_vld[0]});
    chk("rr_pending", pd_rr, m_pend[0]);
    chk("rr_ovf", {3'b0, ovf_rr}, {3'b0, m_ovf[0]});
    chk("fp_onehot", oh_fp, m_oh[1]);
    chk("fp_valid", {3'b0, vld_fp}, {3'b0, m_vld[1]});
    chk("fp_pending", pd_fp, m_pend[1]);
    chk("fp_ovf", {3'b0, ovf_fp}, {3'b0, m_ovf[1]});
    chk("rr_inv", {3'b0, (vld_rr ? $onehot(oh_rr) : (oh_rr == 0))}, 4'b0001);
    chk("fp_inv", {3'b0, (vld_fp ? $onehot(oh_fp) : (oh_fp == 0))}, 4'b0001);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(logic [3:0] r);
    req_in = r;
    tick();
    req_in = 4'b0000;
  endtask

  initial begin
    m_ptr = 0;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 0; m_oh[d] = 0; m_vld[d] = 0; m_ovf[d] = 0;
    end
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(10);

    ready_in = 1'b1;
    req_in = 4'b0100;
    run(6);
    req_in = 4'b0000;
    run(3);

    pulse(4'b1111);
    run(8);
    pulse(4'b0010);
    run(5);
    pulse(4'b1111);
    run(8);

    pulse(4'b0101);
    run(6);

    ready_in = 1'b0;
    pulse(4'b0010);
    run(5);
    pulse(4'b0010);
    run(4);
    pulse(4'b0010);
    run(4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    run(2);
    ready_in = 1'b1;
    run(5);

    ready_in = 1'b0;
    pulse(4'b1011);
    run(4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ready_in = 1'b1;
    run(8);

    for (int i = 0; i < 3000; i++) begin
      req_in   = req_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      ready_in = ($urandom % 4) != 0;
      clr_ovf  = ($urandom % 12) == 0;
      rst_n    = ($urandom % 300) != 0;
      tick();
    end
    rst_n = 1'b1;
    req_in = 4'b0000;
    clr_ovf = 1'b0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
